// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge: AXI4 master behind the data-cache second stage.
// Independent read and write engines; cached accesses move a 256-bit line as
// an 8-beat INCR burst, uncached accesses move a single 32-bit beat. A read
// that targets a line with a write pending or in flight waits for that write.
module dcache_axi_bridge #(
    parameter logic [3:0] AXI_ID     = 4'd1,
    parameter int         LINE_BEATS = 8
) (
    input  logic         Clk,
    input  logic         Rest,
    input  logic         DcaReadAble,
    input  logic         DUnacheRead,
    input  logic [31:0]  DcaReadAddr,
    output logic         DRshankhand,
    output logic [255:0] DcaRDate,
    input  logic         DcaWriteAble,
    input  logic         DWriteUncache,
    input  logic [3:0]   UncacheStrb,
    input  logic [31:0]  DcaWriteAddr,
    input  logic [255:0] DcaWDate,
    output logic         DWshankhand,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [31:0]  rdata,
    input  logic         rlast,
    input  logic         rvalid,
    input  logic [1:0]   rresp,
    output logic         rready,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    localparam logic [7:0] LINE_LEN = 8'(LINE_BEATS - 1);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} r_state_e;
    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_DONE} w_state_e;

    r_state_e       r_state_q, r_state_d;
    logic [31:0]    r_addr_q,  r_addr_d;
    logic           r_unc_q,   r_unc_d;
    logic [2:0]     r_cnt_q,   r_cnt_d;
    logic [255:0]   r_line_q,  r_line_d;
    logic [255:0]   r_data_q,  r_data_d;

    w_state_e       w_state_q, w_state_d;
    logic [31:0]    w_addr_q,  w_addr_d;
    logic           w_unc_q,   w_unc_d;
    logic [3:0]     w_strb_q,  w_strb_d;
    logic [2:0]     w_cnt_q,   w_cnt_d;
    logic [255:0]   w_line_q,  w_line_d;

    logic           hazard_s;
    logic [7:0]     r_len_s;
    logic [7:0]     w_len_s;
    logic           w_last_s;
    logic           unused_resp_s;

    // Responses are never retried, so their codes are deliberately dropped.
    assign unused_resp_s = ^{rresp, bresp};

    // Same-line write (requested or still in flight) keeps a new read parked.
    assign hazard_s = (DcaWriteAble && (DcaWriteAddr[31:5] == DcaReadAddr[31:5])) ||
                      ((w_state_q != W_IDLE) && (w_addr_q[31:5] == DcaReadAddr[31:5]));

    assign r_len_s  = r_unc_q ? 8'd0 : LINE_LEN;
    assign w_len_s  = w_unc_q ? 8'd0 : LINE_LEN;
    assign w_last_s = (w_state_q == W_DATA) && ({5'd0, w_cnt_q} == w_len_s);

    assign arid        = AXI_ID;
    assign araddr      = r_addr_q;
    assign arlen       = r_len_s;
    assign arsize      = 3'b010;
    assign arburst     = 2'b01;
    assign arvalid     = (r_state_q == R_ADDR);
    assign rready      = (r_state_q == R_DATA);
    assign DRshankhand = (r_state_q == R_DONE);
    assign DcaRDate    = r_data_q;

    assign awid        = AXI_ID;
    assign awaddr      = w_addr_q;
    assign awlen       = w_len_s;
    assign awsize      = 3'b010;
    assign awburst     = 2'b01;
    assign awvalid     = (w_state_q == W_ADDR);
    assign wvalid      = (w_state_q == W_DATA);
    assign wdata       = w_line_q[{w_cnt_q, 5'd0} +: 32];
    assign wstrb       = w_unc_q ? w_strb_q : 4'hF;
    assign wlast       = w_last_s;
    assign bready      = (w_state_q == W_RESP);
    assign DWshankhand = (w_state_q == W_DONE);

    // Read engine next state: accept, AR handshake, collect beats, retire.
    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_unc_d   = r_unc_q;
        r_cnt_d   = r_cnt_q;
        r_line_d  = r_line_q;
        r_data_d  = r_data_q;
        case (r_state_q)
            R_IDLE: begin
                if (DcaReadAble && !hazard_s) begin
                    r_unc_d   = DUnacheRead;
                    r_addr_d  = DUnacheRead ? DcaReadAddr : {DcaReadAddr[31:5], 5'd0};
                    r_cnt_d   = 3'd0;
                    r_state_d = R_ADDR;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_ADDR: begin
                if (arready) begin
                    r_state_d = R_DATA;
                end else begin
                    r_state_d = R_ADDR;
                end
            end
            R_DATA: begin
                if (rvalid) begin
                    r_line_d[{r_cnt_q, 5'd0} +: 32] = rdata;
                    r_cnt_d = r_cnt_q + 3'd1;
                    if (rlast || ({5'd0, r_cnt_q} == r_len_s)) begin
                        // Result register only changes when a read completes.
                        r_data_d  = r_unc_q ? {224'd0, rdata} : r_line_d;
                        r_state_d = R_DONE;
                    end else begin
                        r_state_d = R_DATA;
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            R_DONE: begin
                r_state_d = R_IDLE;
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Write engine next state: accept, AW handshake, stream beats, await B.
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_unc_d   = w_unc_q;
        w_strb_d  = w_strb_q;
        w_cnt_d   = w_cnt_q;
        w_line_d  = w_line_q;
        case (w_state_q)
            W_IDLE: begin
                if (DcaWriteAble) begin
                    w_unc_d   = DWriteUncache;
                    w_addr_d  = DWriteUncache ? DcaWriteAddr : {DcaWriteAddr[31:5], 5'd0};
                    w_strb_d  = UncacheStrb;
                    w_line_d  = DcaWDate;
                    w_cnt_d   = 3'd0;
                    w_state_d = W_ADDR;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_ADDR: begin
                if (awready) begin
                    w_state_d = W_DATA;
                end else begin
                    w_state_d = W_ADDR;
                end
            end
            W_DATA: begin
                if (wready && w_last_s) begin
                    w_state_d = W_RESP;
                end else if (wready) begin
                    w_cnt_d = w_cnt_q + 3'd1;
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                if (bvalid) begin
                    w_state_d = W_DONE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            W_DONE: begin
                w_state_d = W_IDLE;
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Read engine registers; reset abandons any burst without a handshake.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= 32'd0;
            r_unc_q   <= 1'b0;
            r_cnt_q   <= 3'd0;
            r_line_q  <= 256'd0;
            r_data_q  <= 256'd0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_unc_q   <= r_unc_d;
            r_cnt_q   <= r_cnt_d;
            r_line_q  <= r_line_d;
            r_data_q  <= r_data_d;
        end
    end

    // Write engine registers; reset abandons any burst without a handshake.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= 32'd0;
            w_unc_q   <= 1'b0;
            w_strb_q  <= 4'd0;
            w_cnt_q   <= 3'd0;
            w_line_q  <= 256'd0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_unc_q   <= w_unc_d;
            w_strb_q  <= w_strb_d;
            w_cnt_q   <= w_cnt_d;
            w_line_q  <= w_line_d;
        end
    end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Bench for dcache_axi_bridge: requester tasks push expected AXI requests,
// write beats and read lines into queues; a randomly stalling AXI slave and a
// handshake monitor pop and compare whenever the DUT presents a transfer.
module tb_dcache_axi_bridge;

    logic         Clk = 1'b0;
    logic         Rest = 1'b0;
    logic         DcaReadAble = 1'b0, DUnacheRead = 1'b0;
    logic [31:0]  DcaReadAddr = 32'd0;
    logic         DRshankhand;
    logic [255:0] DcaRDate;
    logic         DcaWriteAble = 1'b0, DWriteUncache = 1'b0;
    logic [3:0]   UncacheStrb = 4'd0;
    logic [31:0]  DcaWriteAddr = 32'd0;
    logic [255:0] DcaWDate = 256'd0;
    logic         DWshankhand;
    logic [3:0]   arid, awid;
    logic [31:0]  araddr, awaddr, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst;
    logic         arvalid, awvalid, wvalid, wlast, rready, bready;
    logic [3:0]   wstrb;
    logic         arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [31:0]  rdata = 32'd0;
    logic [1:0]   rresp = 2'd0, bresp = 2'd0;
    logic         awready = 1'b0, wready = 1'b0, bvalid = 1'b0;

    int total = 0;
    int bad = 0;

    logic [39:0]  ar_exp_q[$];
    logic [255:0] rsrc_q[$];
    logic [255:0] rline_exp_q[$];
    logic [255:0] rburst_line_q[$];
    logic [7:0]   rburst_len_q[$];
    logic [39:0]  aw_exp_q[$];
    logic [36:0]  wb_exp_q[$];
    int           wr_exp_cnt = 0;
    int           rbeat = 0;
    int           b_acc = 0;
    logic         aw_stall = 1'b0;
    longint       last_ar_time = 0;
    longint       last_dws_time = 0;

    dcache_axi_bridge dut (
        .Clk(Clk), .Rest(Rest),
        .DcaReadAble(DcaReadAble), .DUnacheRead(DUnacheRead), .DcaReadAddr(DcaReadAddr),
        .DRshankhand(DRshankhand), .DcaRDate(DcaRDate),
        .DcaWriteAble(DcaWriteAble), .DWriteUncache(DWriteUncache), .UncacheStrb(UncacheStrb),
        .DcaWriteAddr(DcaWriteAddr), .DcaWDate(DcaWDate), .DWshankhand(DWshankhand),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rresp(rresp), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        total++;
        bad++;
        $display("FAIL %s (expected event missing or unexpected event)", name);
    endtask

    // Reference: cached requests align to the 32-byte line and ask for 8 beats.
    function automatic logic [39:0] exp_req(input logic [31:0] a, input logic unc);
        logic [31:0] base;
        base = unc ? a : (a & 32'hFFFF_FFE0);
        return {base, unc ? 8'd0 : 8'd7};
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic do_read(input logic [31:0] addr, input logic unc, input logic [255:0] src);
        logic got;
        ar_exp_q.push_back(exp_req(addr, unc));
        rsrc_q.push_back(src);
        rline_exp_q.push_back(unc ? {224'd0, src[31:0]} : src);
        @(negedge Clk);
        DcaReadAddr = addr;
        DUnacheRead = unc;
        DcaReadAble = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge Clk);
            if (DRshankhand) got = 1'b1;
        end
        if (!got) fail_msg("read_timeout");
        DcaReadAble = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic unc, input logic [3:0] strb,
                            input logic [255:0] line);
        logic got;
        int   n;
        aw_exp_q.push_back(exp_req(addr, unc));
        n = unc ? 1 : 8;
        for (int i = 0; i < n; i++)
            wb_exp_q.push_back({line[32*i +: 32], unc ? strb : 4'hF, (i == n - 1)});
        wr_exp_cnt++;
        @(negedge Clk);
        DcaWriteAddr  = addr;
        DWriteUncache = unc;
        UncacheStrb   = strb;
        DcaWDate      = line;
        DcaWriteAble  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge Clk);
            if (DWshankhand) got = 1'b1;
        end
        if (!got) fail_msg("write_timeout");
        DcaWriteAble = 1'b0;
    endtask

    // AXI slave with random stalls; checks every AR/AW/W transfer it takes.
    initial begin : slave
        logic         r_hold, b_hold;
        logic [255:0] cur_line;
        logic [39:0]  e;
        logic [36:0]  eb;
        int           aw_acc, w_bursts, b_pend;
        r_hold = 1'b0; b_hold = 1'b0; aw_acc = 0; w_bursts = 0; b_pend = 0;
        forever begin
            @(negedge Clk);
            if (!Rest) begin
                rburst_line_q.delete();
                rburst_len_q.delete();
                rbeat = 0; r_hold = 1'b0; b_hold = 1'b0;
                aw_acc = 0; w_bursts = 0; b_pend = 0;
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            end else begin
                // R channel
                if (!r_hold) begin
                    if (rburst_line_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                        cur_line = rburst_line_q[0];
                        rvalid = 1'b1;
                        rdata  = cur_line[32*rbeat +: 32];
                        rlast  = (rbeat == int'(rburst_len_q[0]));
                        rresp  = 2'($urandom_range(0, 3));
                    end else begin
                        rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
                    end
                end
                if (rvalid && rready) begin
                    r_hold = 1'b0;
                    if (rlast) begin
                        void'(rburst_line_q.pop_front());
                        void'(rburst_len_q.pop_front());
                        rbeat = 0;
                    end else begin
                        rbeat++;
                    end
                end else begin
                    r_hold = rvalid;
                end
                // AR channel
                arready = ($urandom_range(0, 2) != 0);
                if (arvalid && arready) begin
                    last_ar_time = $time;
                    if (ar_exp_q.size() == 0 || rsrc_q.size() == 0) begin
                        fail_msg("ar_unexpected");
                    end else begin
                        e = ar_exp_q.pop_front();
                        chk("ar_request", 256'({arid, araddr, arlen, arsize, arburst}),
                            256'({4'd1, e, 3'b010, 2'b01}));
                        rburst_line_q.push_back(rsrc_q.pop_front());
                        rburst_len_q.push_back(e[7:0]);
                    end
                end
                // B channel
                if (!b_hold) begin
                    bvalid = (b_pend > 0) && ($urandom_range(0, 2) != 0);
                    bresp  = 2'($urandom_range(0, 3));
                end
                if (bvalid && bready) begin
                    b_hold = 1'b0;
                    b_pend--;
                    b_acc++;
                end else begin
                    b_hold = bvalid;
                end
                // W channel (before AW so an early beat is caught)
                wready = ($urandom_range(0, 2) != 0);
                if (wvalid && wready) begin
                    chk("w_after_aw", 256'(aw_acc > w_bursts), 256'd1);
                    if (wb_exp_q.size() == 0) begin
                        fail_msg("w_unexpected");
                    end else begin
                        eb = wb_exp_q.pop_front();
                        chk("w_beat", 256'({wdata, wstrb, wlast}), 256'(eb));
                        if (eb[0]) begin
                            w_bursts++;
                            b_pend++;
                        end
                    end
                end
                // AW channel
                awready = aw_stall ? 1'b0 : ($urandom_range(0, 2) != 0);
                if (awvalid && awready) begin
                    aw_acc++;
                    if (aw_exp_q.size() == 0) begin
                        fail_msg("aw_unexpected");
                    end else begin
                        e = aw_exp_q.pop_front();
                        chk("aw_request", 256'({awid, awaddr, awlen, awsize, awburst}),
                            256'({4'd1, e, 3'b010, 2'b01}));
                    end
                end
            end
        end
    end

    // Handshake monitor: each retire pulse is one cycle, expected, and correct.
    initial begin : monitor
        logic prev_drs, prev_dws;
        int   dws_cnt;
        prev_drs = 1'b0; prev_dws = 1'b0; dws_cnt = 0;
        forever begin
            @(negedge Clk);
            if (DRshankhand) begin
                chk("drs_one_cycle", 256'(prev_drs), 256'd0);
                if (rline_exp_q.size() == 0) fail_msg("drs_unexpected");
                else chk("read_line", DcaRDate, rline_exp_q.pop_front());
            end
            if (DWshankhand) begin
                chk("dws_one_cycle", 256'(prev_dws), 256'd0);
                chk("dws_after_b", 256'(b_acc > dws_cnt), 256'd1);
                chk("dws_expected", 256'(wr_exp_cnt > 0), 256'd1);
                if (wr_exp_cnt > 0) wr_exp_cnt--;
                dws_cnt++;
                last_dws_time = $time;
            end
            prev_drs = DRshankhand;
            prev_dws = DWshankhand;
        end
    end

    initial begin : stimulus
        logic [255:0] src;
        logic         got;
        int           blocked;
        @(negedge Clk);
        chk("reset_outs", 256'({arvalid, rready, awvalid, wvalid, wlast, bready, DRshankhand, DWshankhand}), 256'd0);
        chk("reset_rdate", DcaRDate, 256'd0);
        chk("axi_consts", 256'({arid, arsize, arburst, awid, awsize, awburst}),
            256'({4'd1, 3'b010, 2'b01, 4'd1, 3'b010, 2'b01}));
        @(negedge Clk);
        Rest = 1'b1;

        // Cached read, slave returns beat index as data
        for (int i = 0; i < 8; i++) src[32*i +: 32] = 32'(i);
        do_read(32'h1C00_0024, 1'b0, src);
        // Uncached read: upper source words must not leak into the result
        src = rand_line();
        src[31:0] = 32'hDEAD_BEEF;
        do_read(32'hBFAF_8000, 1'b1, src);
        // Cached and uncached writes
        do_write(32'h0000_1040, 1'b0, 4'h0, rand_line());
        do_write(32'h0000_1844, 1'b1, 4'b0011, rand_line());

        // Same-line hazard: write held at AW, read must not issue
        aw_stall = 1'b1;
        fork
            do_write(32'h0000_2000, 1'b0, 4'hF, rand_line());
            begin
                repeat (2) @(negedge Clk);
                do_read(32'h0000_2010, 1'b0, rand_line());
            end
            begin
                blocked = 0;
                repeat (30) begin
                    @(negedge Clk);
                    if (arvalid) blocked++;
                end
                chk("hazard_ar_blocked", 256'(blocked), 256'd0);
                aw_stall = 1'b0;
            end
        join
        chk("hazard_ar_after_dws", 256'(last_ar_time > last_dws_time), 256'd1);

        // Concurrent random traffic over a few lines
        fork
            for (int k = 0; k < 20; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge Clk);
                do_read(32'h0000_8000 | ($urandom & 32'h0000_007C), 1'($urandom_range(0, 1)), rand_line());
            end
            for (int k = 0; k < 20; k++) begin
                repeat ($urandom_range(0, 3)) @(negedge Clk);
                do_write(32'h0000_8000 | ($urandom & 32'h0000_007C), 1'($urandom_range(0, 1)),
                         4'($urandom_range(1, 15)), rand_line());
            end
        join

        // Reset in the middle of a read burst
        src = rand_line();
        ar_exp_q.push_back(exp_req(32'h3000_0040, 1'b0));
        rsrc_q.push_back(src);
        rline_exp_q.push_back(src);
        @(negedge Clk);
        DcaReadAddr = 32'h3000_0040;
        DUnacheRead = 1'b0;
        DcaReadAble = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge Clk);
            #1;
            if (rbeat == 3) got = 1'b1;
        end
        if (!got) fail_msg("reset_wait_beat3");
        Rest = 1'b0;
        DcaReadAble = 1'b0;
        #1;
        chk("reset_mid_burst_outs", 256'({arvalid, rready, DRshankhand}), 256'd0);
        chk("reset_mid_burst_rdate", DcaRDate, 256'd0);
        ar_exp_q.delete();
        rsrc_q.delete();
        rline_exp_q.delete();
        repeat (3) @(negedge Clk);
        Rest = 1'b1;
        do_read(32'h3000_0044, 1'b0, rand_line());
        do_read(32'h3000_0048, 1'b1, rand_line());

        repeat (5) @(negedge Clk);
        chk("queues_drained", 256'({ar_exp_q.size(), aw_exp_q.size(), wb_exp_q.size(), rline_exp_q.size()}),
            256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
